// File: rtl/add_scrambler_par.sv
// Additive scrambler/descrambler, DATA_W bits per beat, valid/ready.
// Programmable taps/seed, resync, frame auto-reload and bypass.
//
// Ports:
//   clk_i, rstn_i         clock, async active-low reset
//   bypass_i              pass data through; LFSR holds (pending load applied)
//   sync_i, seed_i        restart the key stream from seed_i on this beat
//   valid_i, data_i       input beat (data_i[0] earliest in time)
//   ready_o               input beat can be accepted
//   valid_o, data_o       registered output beat
//   ready_i               downstream accepts the output beat
module add_scrambler_par #(
    parameter int                  DATA_W    = 8,
    parameter int                  LFSR_LEN  = 7,
    parameter logic [LFSR_LEN-1:0] POLY      = 7'h60,
    parameter logic [LFSR_LEN-1:0] SEED      = 7'h7F,
    parameter int                  FRAME_LEN = 0
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                bypass_i,
    input  logic                sync_i,
    input  logic [LFSR_LEN-1:0] seed_i,
    input  logic                valid_i,
    input  logic [DATA_W-1:0]   data_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [DATA_W-1:0]   data_o,
    input  logic                ready_i
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((FRAME_LEN > 0) ? FRAME_LEN - 1 : 0);
    // The sync beat is beat 0 of a new frame, so the next one is beat 1
    // (which wraps straight back to 0 for one-beat frames).
    localparam logic [CNT_W-1:0] CNT_SYNC =
        CNT_W'((FRAME_LEN > 1) ? 1 : 0);

    logic [LFSR_LEN-1:0] lfsr;
    logic [LFSR_LEN-1:0] load_val;
    logic [LFSR_LEN-1:0] start;
    logic [LFSR_LEN-1:0] walk;
    logic [DATA_W-1:0]   key;
    logic [CNT_W-1:0]    beat_cnt;
    logic                first_beat;
    logic                accept;
    logic                reload;
    logic                use_load;

    assign ready_o  = !valid_o | ready_i;
    assign accept   = valid_i & ready_o;
    // The first beat after reset already starts from SEED.
    assign reload   = (FRAME_LEN > 0) && (beat_cnt == '0) && !first_beat;
    assign use_load = sync_i | reload;

    always_comb begin
        load_val = sync_i ? seed_i : SEED;
        // An all-zero LFSR would lock up; substitute all ones.
        if (load_val == '0) begin
            load_val = '1;
        end
        start = use_load ? load_val : lfsr;
    end

    // DATA_W LFSR steps unrolled; walk ends as the post-beat state.
    always_comb begin
        key  = '0;
        walk = start;
        for (int j = 0; j < DATA_W; j++) begin
            key[j] = ^(walk & POLY);
            walk   = {walk[LFSR_LEN-2:0], key[j]};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lfsr       <= SEED;
            valid_o    <= 1'b0;
            data_o     <= '0;
            beat_cnt   <= '0;
            first_beat <= 1'b1;
        end else if (accept) begin
            valid_o    <= 1'b1;
            first_beat <= 1'b0;
            if (bypass_i) begin
                data_o <= data_i;
                lfsr   <= start;
            end else begin
                data_o <= data_i ^ key;
                lfsr   <= walk;
            end
            if (FRAME_LEN > 0) begin
                if (sync_i) begin
                    beat_cnt <= CNT_SYNC;
                end else if (beat_cnt == CNT_LAST) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_scrambler_par.sv
// Self-checking bench for add_scrambler_par.
// Table vectors, random stream vs. model, chained round trip, reset.
module tb_add_scrambler_par;

    localparam int SEED_V = 'h7F;
    localparam int POLY_V = 'h60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: key stream generated bit by bit from the tap rule,
    // frame position counted as beats since the last frame start.
    typedef struct {
        int st;
        int pos;
        bit fresh;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st    = SEED_V;
        m.pos   = 0;
        m.fresh = 1'b1;
        return m;
    endfunction

    task automatic mdl_beat(input mdl_t mi, input int fl,
                            input logic [7:0] d, input bit byp,
                            input bit sy, input logic [6:0] sd,
                            output mdl_t mo, output logic [7:0] q);
        int s;
        int fb;
        s = mi.st;
        if (sy) begin
            s = (sd == 0) ? 127 : int'(sd);
        end else if (fl > 0 && (mi.pos % fl) == 0 && !mi.fresh) begin
            s = SEED_V;
        end
        q = d;
        if (!byp) begin
            for (int j = 0; j < 8; j++) begin
                fb   = $countones(s & POLY_V) % 2;
                q[j] = d[j] ^ fb[0];
                s    = ((s * 2) + fb) % 128;
            end
        end
        mo.st    = s;
        mo.pos   = sy ? 1 : mi.pos + 1;
        mo.fresh = 1'b0;
    endtask

    // Instance 0: defaults, random stream
    logic       rst0, by0, sy0, v0, rdy0, ro0, vo0;
    logic [6:0] sd0;
    logic [7:0] d0, q0;

    add_scrambler_par u0 (
        .clk_i(clk), .rstn_i(rst0), .bypass_i(by0), .sync_i(sy0),
        .seed_i(sd0), .valid_i(v0), .data_i(d0), .ready_o(ro0),
        .valid_o(vo0), .data_o(q0), .ready_i(rdy0)
    );

    // Chained pair: scramble then descramble
    logic       rstc, cv, ra, va, rb, vb;
    logic [7:0] cd, qa, qb;

    add_scrambler_par u2a (
        .clk_i(clk), .rstn_i(rstc), .bypass_i(1'b0), .sync_i(1'b0),
        .seed_i(7'h00), .valid_i(cv), .data_i(cd), .ready_o(ra),
        .valid_o(va), .data_o(qa), .ready_i(rb)
    );

    add_scrambler_par u2b (
        .clk_i(clk), .rstn_i(rstc), .bypass_i(1'b0), .sync_i(1'b0),
        .seed_i(7'h00), .valid_i(va), .data_i(qa), .ready_o(rb),
        .valid_o(vb), .data_o(qb), .ready_i(1'b1)
    );

    // Instance 3: four-beat frames
    logic       rst3, by3, sy3, v3, ro3, vo3;
    logic [6:0] sd3;
    logic [7:0] d3, q3;

    add_scrambler_par #(.FRAME_LEN(4)) u3 (
        .clk_i(clk), .rstn_i(rst3), .bypass_i(by3), .sync_i(sy3),
        .seed_i(sd3), .valid_i(v3), .data_i(d3), .ready_o(ro3),
        .valid_o(vo3), .data_o(q3), .ready_i(1'b1)
    );

    typedef struct {
        logic [7:0] d;
        bit         byp;
        bit         sy;
        logic [6:0] sd;
        logic [7:0] exp;
        bit         fixed;
    } vec_t;

    vec_t       tbl [18];
    logic [7:0] hist [64];

    task automatic u3_beat(input logic [7:0] d, input bit byp,
                           input bit sy, input logic [6:0] sd,
                           input logic [7:0] exp, input string name);
        v3  = 1'b1;
        d3  = d;
        by3 = byp;
        sy3 = sy;
        sd3 = sd;
        @(negedge clk);
        check({name, "_valid"}, vo3, 1'b1);
        check({name, "_data"}, q3, exp);
        v3  = 1'b0;
        by3 = 1'b0;
        sy3 = 1'b0;
    endtask

    task automatic u3_reset();
        rst3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        mdl_t       m0, mn, m3;
        logic [7:0] ed, q;
        bit         ev, acc, stall;

        rst0 = 1'b0; by0 = 1'b0; sy0 = 1'b0; sd0 = '0;
        v0 = 1'b0; d0 = '0; rdy0 = 1'b1;
        rstc = 1'b0; cv = 1'b0; cd = '0;
        rst3 = 1'b0; by3 = 1'b0; sy3 = 1'b0; sd3 = '0;
        v3 = 1'b0; d3 = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", vo0, 1'b0);
        check("rst_data", q0, 8'h00);
        rst0 = 1'b1;
        @(negedge clk);
        check("rst_ready", ro0, 1'b1);
        check("rst_valid_post", vo0, 1'b0);

        // First beat of zeros
        m0 = mdl_reset();
        v0 = 1'b1;
        d0 = 8'h00;
        mdl_beat(m0, 0, d0, 1'b0, 1'b0, 7'h00, mn, ed);
        m0 = mn;
        ev = 1'b1;
        @(negedge clk);
        check("first_beat_valid", vo0, 1'b1);
        check("first_beat_data", q0, 8'h40);

        // Random stream with back-pressure, including a 5-cycle stall
        for (int c = 0; c < 200; c++) begin
            check("rnd_valid", vo0, ev);
            check("rnd_data", q0, ed);
            stall = (c >= 50 && c < 55);
            rdy0 = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            v0   = stall ? 1'b1 : ($urandom_range(0, 3) != 0);
            d0   = 8'($urandom);
            by0  = ($urandom_range(0, 7) == 0);
            sy0  = ($urandom_range(0, 15) == 0);
            sd0  = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
            #1;
            check("rnd_ready", ro0, !ev || rdy0);
            if (stall && c > 50) begin
                check("stall_ready", ro0, 1'b0);
            end
            acc = v0 && (!ev || rdy0);
            if (acc) begin
                mdl_beat(m0, 0, d0, by0, sy0, sd0, mn, q);
                m0 = mn;
                ed = q;
                ev = 1'b1;
            end else if (rdy0) begin
                ev = 1'b0;
            end
            @(negedge clk);
        end
        check("rnd_valid_end", vo0, ev);
        check("rnd_data_end", q0, ed);

        // Reset pulse while an output is pending
        by0 = 1'b0; sy0 = 1'b0; rdy0 = 1'b1; v0 = 1'b1; d0 = 8'h11;
        @(negedge clk);
        v0 = 1'b0;
        rdy0 = 1'b0;
        check("pre_rst_valid", vo0, 1'b1);
        #2 rst0 = 1'b0;
        #1;
        check("async_rst_valid", vo0, 1'b0);
        check("async_rst_data", q0, 8'h00);
        @(negedge clk);
        #2 rst0 = 1'b1;
        @(negedge clk);
        v0 = 1'b1;
        d0 = 8'h00;
        rdy0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        check("post_rst_valid", vo0, 1'b1);
        check("post_rst_data", q0, 8'h40);

        // Chained round trip
        @(negedge clk);
        rstc = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 66; i++) begin
            if (i >= 2) begin
                check("chain_valid", vb, 1'b1);
                check("chain_data", qb, hist[i-2]);
            end
            if (i < 64) begin
                cv = 1'b1;
                cd = 8'($urandom);
                hist[i] = cd;
            end else begin
                cv = 1'b0;
            end
            @(negedge clk);
        end

        // Frame table: reloads, sync with zero seed, bypass
        foreach (tbl[i]) begin
            tbl[i].d = 8'h00;
            tbl[i].byp = 1'b0;
            tbl[i].sy = 1'b0;
            tbl[i].sd = 7'h00;
            tbl[i].exp = 8'h00;
            tbl[i].fixed = 1'b0;
        end
        tbl[0].exp = 8'h40;  tbl[0].fixed = 1'b1;
        tbl[4].exp = 8'h40;  tbl[4].fixed = 1'b1;
        tbl[8].d = 8'hA5;
        tbl[9].d = 8'h3C;
        tbl[10].sy = 1'b1;   tbl[10].exp = 8'h40; tbl[10].fixed = 1'b1;
        tbl[11].d = 8'hFF;
        tbl[12].byp = 1'b1;  tbl[12].exp = 8'h00; tbl[12].fixed = 1'b1;
        tbl[14].d = 8'h81;   tbl[14].sy = 1'b1;   tbl[14].sd = 7'h15;
        m3 = mdl_reset();
        foreach (tbl[i]) begin
            mdl_beat(m3, 4, tbl[i].d, tbl[i].byp, tbl[i].sy, tbl[i].sd,
                     mn, q);
            m3 = mn;
            if (!tbl[i].fixed) begin
                tbl[i].exp = q;
            end
        end
        u3_reset();
        foreach (tbl[i]) begin
            u3_beat(tbl[i].d, tbl[i].byp, tbl[i].sy, tbl[i].sd,
                    tbl[i].exp, $sformatf("frame_tbl%0d", i));
        end

        // Bypass on beat 1: beat 2 carries the key beat 1 would have had
        m3 = mdl_reset();
        mdl_beat(m3, 4, 8'h00, 1'b0, 1'b0, 7'h00, mn, q);
        m3 = mn;
        mdl_beat(m3, 4, 8'h00, 1'b0, 1'b0, 7'h00, mn, ed);
        u3_reset();
        u3_beat(8'h00, 1'b0, 1'b0, 7'h00, 8'h40, "byp_beat0");
        u3_beat(8'h00, 1'b1, 1'b0, 7'h00, 8'h00, "byp_beat1");
        u3_beat(8'h00, 1'b0, 1'b0, 7'h00, ed, "byp_beat2");
        @(negedge clk);
        check("byp_retire", vo3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
